// File: rtl/seq_shift_unit_pkg.sv
// Shared definitions for the sequential shift unit: operation mode codes and FSM states.
// Rotate support is selected at build time with SEQ_SHIFT_ROTATE_EN.
package shift_pkg;

    localparam logic [1:0] MODE_SRL = 2'b00;
    localparam logic [1:0] MODE_SLL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/seq_shift_unit_shift_stage.sv
// One barrel-shifter stage: conditionally shifts/rotates a word by a power-of-two distance.
// The rotate path exists only when SEQ_SHIFT_ROTATE_EN is defined.
module shift_stage
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int LOG2W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] word_i,
    input  logic             en_i,
    input  logic [LOG2W-1:0] dist_i,
    input  logic [1:0]       mode_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] word_o
);

    logic [WIDTH-1:0] fill_mask;
`ifdef SEQ_SHIFT_ROTATE_EN
    logic [LOG2W:0]   rdist;
`endif

    always_comb begin
        // Bits vacated by a right shift; they are replaced with the fill bit.
        fill_mask = ~({WIDTH{1'b1}} >> dist_i);
`ifdef SEQ_SHIFT_ROTATE_EN
        rdist     = (LOG2W+1)'(WIDTH) - {1'b0, dist_i};
`endif
        word_o    = word_i;
        if (en_i) begin
            case (mode_i)
                MODE_SLL: word_o = word_i << dist_i;
`ifdef SEQ_SHIFT_ROTATE_EN
                MODE_ROR: word_o = (word_i >> dist_i) | (word_i << rdist);
`endif
                default:  word_o = (word_i >> dist_i) | (fill_mask & {WIDTH{fill_i}});
            endcase
        end
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: one shift-amount bit per cycle through a single reused stage.
// Rotate-right (mode 11) is built only when SEQ_SHIFT_ROTATE_EN is defined; otherwise mode 11 acts as SRL.
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    localparam int LOG2W = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [LOG2W-1:0] amt_q, amt_d;
    logic [LOG2W-1:0] k_q, k_d;
    logic [1:0]       mode_q, mode_d;
    logic             fill_q, fill_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_zero_q, out_zero_d;

    logic [1:0]       acc_mode;
    logic             acc_fill;
    logic             acc_ovf;
    logic             acc_rot;
    logic             last_step;
    logic             stage_en;
    logic [LOG2W-1:0] stage_dist;
    logic [WIDTH-1:0] stage_word;

    // Operand decode at accept time.
    always_comb begin
        acc_ovf = |in_amt[WIDTH-1:LOG2W];
        acc_fill = (in_mode == MODE_SRA) ? in_data[WIDTH-1] : 1'b0;
`ifdef SEQ_SHIFT_ROTATE_EN
        acc_mode = in_mode;
        acc_rot  = (in_mode == MODE_ROR);
`else
        acc_mode = (in_mode == MODE_ROR) ? MODE_SRL : in_mode;
        acc_rot  = 1'b0;
`endif
    end

    // The amount register is consumed LSB-first, so amt_q[0] always belongs to stage k_q.
    always_comb begin
        last_step  = (k_q == LOG2W'(LOG2W));
        stage_en   = (state_q == S_SHIFT) && !last_step && amt_q[0];
        stage_dist = LOG2W'(1) << k_q;
    end

    shift_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .word_i (data_q),
        .en_i   (stage_en),
        .dist_i (stage_dist),
        .mode_i (mode_q),
        .fill_i (fill_q),
        .word_o (stage_word)
    );

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        amt_d       = amt_q;
        k_d         = k_q;
        mode_d      = mode_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_zero_d  = out_zero_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Overflowed non-rotate ops preload the all-fill result and still run every stage.
                    data_d  = (acc_ovf && !acc_rot) ? {WIDTH{acc_fill}} : in_data;
                    amt_d   = in_amt[LOG2W-1:0];
                    mode_d  = acc_mode;
                    fill_d  = acc_fill;
                    k_d     = '0;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_step) begin
                    out_valid_d = 1'b1;
                    out_data_d  = data_q;
                    out_zero_d  = (data_q == '0);
                    state_d     = S_DONE;
                end else begin
                    data_d = stage_word;
                    amt_d  = amt_q >> 1;
                    k_d    = k_q + LOG2W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_zero_d  = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            data_q      <= '0;
            amt_q       <= '0;
            k_q         <= '0;
            mode_q      <= MODE_SRL;
            fill_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            amt_q       <= amt_d;
            k_q         <= k_d;
            mode_q      <= mode_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit (WIDTH=32) against a plain-arithmetic shift model.
// Honours SEQ_SHIFT_ROTATE_EN for the expected behaviour of mode 11.
module tb_seq_shift_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] in_amt;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    seq_shift_unit #(
        .WIDTH (WIDTH)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // SV shift operators already give 0 / sign fill for amounts >= 32.
    function automatic logic [31:0] ref_model(input logic [31:0] d, input logic [31:0] a,
                                              input logic [1:0] m);
        case (m)
            2'b01: return d << a;
            2'b10: return 32'($signed(d) >>> a);
`ifdef SEQ_SHIFT_ROTATE_EN
            2'b11: begin
                int unsigned n;
                n = a % 32;
                return (d >> n) | (d << (32 - n));
            end
`endif
            default: return d >> a;
        endcase
    endfunction

    task automatic run_op(input logic [31:0] d, input logic [31:0] a, input logic [1:0] m,
                          input int stall);
        logic [31:0] exp;
        logic [31:0] held;
        int          lat;
        exp = ref_model(d, a, m);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_data  = d;
        in_amt   = a;
        in_mode  = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_amt   = $urandom;
        in_mode  = 2'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd6);
        check("data", out_data, exp);
        check("zero", 32'(out_zero), 32'(exp == 32'd0));
        held = out_data;
        if (stall > 0) begin
            in_valid = 1'b1;
            in_data  = 32'hDEADBEEF;
            in_amt   = 32'd1;
            in_mode  = 2'b00;
            repeat (stall) begin
                @(posedge clk); #1;
                check("bp_valid", 32'(out_valid), 32'd1);
                check("bp_data", out_data, held);
                check("bp_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_mode   = 2'b00;
        out_ready = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_zero", 32'(out_zero), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(32'h80000000, 32'd31, 2'b00, 0);
        run_op(32'h80000000, 32'd4, 2'b10, 0);
        run_op(32'h0000000F, 32'd28, 2'b01, 0);
        run_op(32'h12345678, 32'd0, 2'b00, 0);
        run_op(32'hFFFFFFFF, 32'd32, 2'b00, 0);
        run_op(32'h80000001, 32'h100, 2'b10, 0);
        run_op(32'h00000001, 32'h80000000, 2'b01, 0);
        run_op(32'h00000001, 32'd33, 2'b11, 0);
        run_op(32'hA5A5A5A5, 32'd3, 2'b00, 3);

        // Abort during the third SHIFT cycle; the previous result is still on out_data.
        in_data  = 32'hCAFEF00D;
        in_amt   = 32'd7;
        in_mode  = 2'b10;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_data", out_data, 32'd0);
        check("abort_out_zero", 32'(out_zero), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'hCAFEF00D, 32'd7, 2'b10, 0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] d;
            logic [31:0] a;
            d = $urandom;
            case ($urandom_range(3, 0))
                0:       a = 32'd32;
                1:       a = $urandom;
                default: a = 32'($urandom_range(31, 0));
            endcase
            run_op(d, a, 2'($urandom), int'($urandom_range(2, 0)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected $finish");
        $fatal(1, "time limit");
    end

endmodule
